// File: rtl/qif_pkg.sv
// Shared constants, FSM state encoding and saturation helper for the QIF neuron scheduler.
package qif_pkg;

  localparam int DATA_W     = 8;
  localparam int SUM_W      = 2 * DATA_W + 2;
  localparam int REFR_TICKS = 3;

  localparam logic signed [DATA_W-1:0] V_RESET = DATA_W'(-20);
  localparam logic signed [DATA_W-1:0] V_PEAK  = DATA_W'(50);

  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (DATA_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_UPDATE,
    S_WRITE,
    S_SPIKE,
    S_DONE
  } state_t;

  // Clamp a wide signed sum into the membrane range.
  function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUM_W-1:0] x);
    if (x > SAT_MAX) begin
      return {1'b0, {(DATA_W - 1){1'b1}}};
    end else if (x < SAT_MIN) begin
      return {1'b1, {(DATA_W - 1){1'b0}}};
    end else begin
      return x[DATA_W-1:0];
    end
  endfunction

endpackage

// File: rtl/qif_update.sv
// Combinational QIF membrane update: fire on V >= V_PEAK, otherwise
// V + (V>>>3)^2 + (I>>>2), saturated to the membrane range.
module qif_update
  import qif_pkg::*;
(
  input  logic signed [DATA_W-1:0] v,
  input  logic signed [DATA_W-1:0] i_syn,
  output logic signed [DATA_W-1:0] v_next,
  output logic                     fire
);

  logic signed [DATA_W-1:0]   v_sh;
  logic signed [DATA_W-1:0]   i_sh;
  logic signed [2*DATA_W-1:0] sq;
  logic signed [SUM_W-1:0]    sum;

  assign v_sh = v >>> 3;
  assign i_sh = i_syn >>> 2;
  assign sq   = (2 * DATA_W)'(v_sh) * (2 * DATA_W)'(v_sh);
  assign sum  = SUM_W'(v) + SUM_W'(sq) + SUM_W'(i_sh);

  assign fire   = (v >= V_PEAK);
  assign v_next = fire ? V_RESET : sat(sum);

endmodule

// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed QIF neuron array: one shared update datapath swept over all neurons per tick.
// Define QIF_REFRACTORY_EN to add per-neuron refractory counters (REFR_TICKS from qif_pkg).
module qif_neuron_scheduler
  import qif_pkg::*;
#(
  parameter  int N_NEURONS = 8,
  localparam int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        tick_i,
  input  logic [N_NEURONS*DATA_W-1:0] i_syn_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o,
  output logic                        spike_valid_o,
  output logic [IDX_W-1:0]            spike_idx_o,
  input  logic                        spike_ready_i,
  input  logic [IDX_W-1:0]            rd_idx_i,
  output logic signed [DATA_W-1:0]    rd_v_o
);

  state_t state, state_nxt;

  logic [IDX_W-1:0]                   idx;
  logic                               last;
  logic signed [DATA_W-1:0]           v_mem [N_NEURONS];
  logic [N_NEURONS-1:0][DATA_W-1:0]   i_arr;

  logic signed [DATA_W-1:0] v_cur;
  logic signed [DATA_W-1:0] i_cur;
  logic signed [DATA_W-1:0] v_upd;
  logic                     fire_upd;
  logic signed [DATA_W-1:0] v_eff;
  logic                     fire_eff;
  logic signed [DATA_W-1:0] v_nxt_q;
  logic                     fire_q;

  assign i_arr  = i_syn_i;
  assign last   = (idx == IDX_W'(N_NEURONS - 1));
  assign rd_v_o = v_mem[rd_idx_i];

  qif_update u_update (
    .v      (v_cur),
    .i_syn  (i_cur),
    .v_next (v_upd),
    .fire   (fire_upd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    busy_o        = (state != S_IDLE);
    done_o        = (state == S_DONE);
    spike_valid_o = (state == S_SPIKE);
    case (state)
      S_IDLE:   if (tick_i) state_nxt = S_READ;
      S_READ:   state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_WRITE;
      S_WRITE: begin
        if (fire_q)    state_nxt = S_SPIKE;
        else if (last) state_nxt = S_DONE;
        else           state_nxt = S_READ;
      end
      S_SPIKE:  if (spike_ready_i) state_nxt = last ? S_DONE : S_READ;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

`ifdef QIF_REFRACTORY_EN
  localparam int RW = $clog2(REFR_TICKS + 1);

  logic [RW-1:0] refr_mem [N_NEURONS];
  logic [RW-1:0] refr_cur;

  // A refractory neuron is pinned at V_RESET and cannot fire until its counter drains.
  always_comb begin
    v_eff    = v_upd;
    fire_eff = fire_upd;
    if (refr_cur != '0) begin
      v_eff    = V_RESET;
      fire_eff = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refr_cur <= '0;
      for (int k = 0; k < N_NEURONS; k++) begin
        refr_mem[k] <= '0;
      end
    end else begin
      if (state == S_READ) begin
        refr_cur <= refr_mem[idx];
      end
      if (state == S_WRITE) begin
        if (fire_q) begin
          refr_mem[idx] <= RW'(REFR_TICKS);
        end else if (refr_cur != '0) begin
          refr_mem[idx] <= refr_cur - 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    v_eff    = v_upd;
    fire_eff = fire_upd;
  end
`endif

  // Datapath: operands latched in READ, result registered in UPDATE, committed in WRITE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx         <= '0;
      v_cur       <= '0;
      i_cur       <= '0;
      v_nxt_q     <= '0;
      fire_q      <= 1'b0;
      spike_idx_o <= '0;
      overrun_o   <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        v_mem[k] <= V_RESET;
      end
    end else begin
      if (tick_i && (state != S_IDLE)) begin
        overrun_o <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (tick_i) idx <= '0;
        end
        S_READ: begin
          v_cur <= v_mem[idx];
          i_cur <= i_arr[idx];
        end
        S_UPDATE: begin
          v_nxt_q <= v_eff;
          fire_q  <= fire_eff;
        end
        S_WRITE: begin
          v_mem[idx] <= v_nxt_q;
          if (fire_q) begin
            spike_idx_o <= idx;
          end else if (!last) begin
            idx <= idx + 1'b1;
          end
        end
        S_SPIKE: begin
          if (spike_ready_i && !last) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Self-checking bench for qif_neuron_scheduler against an arithmetic neuron model.
// Honours QIF_REFRACTORY_EN in the model when the design is built with it.
module tb_qif_neuron_scheduler;

  localparam int N = 8;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tick_i = 1'b0;
  logic [N*W-1:0]   i_syn_i = '0;
  logic             busy_o;
  logic             done_o;
  logic             overrun_o;
  logic             spike_valid_o;
  logic [2:0]       spike_idx_o;
  logic             spike_ready_i = 1'b0;
  logic [2:0]       rd_idx_i = '0;
  logic signed [W-1:0] rd_v_o;

  int n_cmp = 0;
  int n_err = 0;
  int mv[N];
  int mref[N];
  int ii[N];
  int exp_q[$];
  int got_q[$];
  int lat;

  qif_neuron_scheduler #(.N_NEURONS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tick_i        (tick_i),
    .i_syn_i       (i_syn_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .overrun_o     (overrun_o),
    .spike_valid_o (spike_valid_o),
    .spike_idx_o   (spike_idx_o),
    .spike_ready_i (spike_ready_i),
    .rd_idx_i      (rd_idx_i),
    .rd_v_o        (rd_v_o)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floorDiv(input int v, input int d);
    int q;
    q = v / d;
    if ((v % d != 0) && (v < 0)) q--;
    return q;
  endfunction

  function automatic int clampV(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // One timestep of the whole array, neurons in index order.
  task automatic modelSweep();
    int q;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      if (mref[k] > 0) begin
        mv[k] = -20;
        mref[k]--;
      end else if (mv[k] >= 50) begin
        mv[k] = -20;
        exp_q.push_back(k);
`ifdef QIF_REFRACTORY_EN
        mref[k] = 3;
`endif
      end else begin
        q = floorDiv(mv[k], 8);
        mv[k] = clampV(mv[k] + q * q + floorDiv(ii[k], 4));
      end
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      mv[k] = -20;
      mref[k] = 0;
    end
  endtask

  task automatic driveI();
    for (int k = 0; k < N; k++) i_syn_i[k*W +: W] = W'(ii[k]);
  endtask

  task automatic checkAllV(input string tag);
    for (int k = 0; k < N; k++) begin
      rd_idx_i = 3'(k);
      #1;
      checkOutput(tag, rd_v_o, mv[k]);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    tick_i = 1'b0;
    spike_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  // Run one sweep; stall<0 picks a random 0..2 cycle stall per spike; extra_tick fires a tick mid-sweep.
  task automatic applyStimulus(input int stall, input int extra_tick);
    int pre[N];
    int cyc, stall_left, total_stall, cur_idx;
    pre = mv;
    driveI();
    modelSweep();
    got_q.delete();
    stall_left = -1;
    total_stall = 0;
    cur_idx = 0;
    @(negedge clk);
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    cyc = 1;
    while (cyc <= 500) begin
      tick_i = (cyc == extra_tick);
      if (done_o) break;
      if (spike_valid_o) begin
        if (stall_left < 0) begin
          cur_idx = int'(spike_idx_o);
          stall_left = (stall < 0) ? int'($urandom_range(0, 2)) : stall;
        end else begin
          checkOutput("idx_stable", spike_idx_o, cur_idx);
        end
        if (stall_left > 0) begin
          spike_ready_i = 1'b0;
          stall_left--;
          total_stall++;
          if (cur_idx < N - 1) begin
            rd_idx_i = 3'(cur_idx + 1);
            #1;
            checkOutput("no_early_read", rd_v_o, pre[cur_idx+1]);
          end
        end else begin
          spike_ready_i = 1'b1;
          got_q.push_back(int'(spike_idx_o));
          stall_left = -1;
        end
      end else begin
        spike_ready_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    tick_i = 1'b0;
    spike_ready_i = 1'b0;
    lat = cyc;
    if (cyc > 500) checkOutput("sweep_timeout", 0, 1);
    checkOutput("latency", cyc, 25 + exp_q.size() + total_stall);
    checkOutput("busy_in_done", busy_o, 1);
    checkOutput("spike_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      checkOutput("spike_idx", got_q[k], exp_q[k]);
    @(negedge clk);
    checkOutput("done_pulse", done_o, 0);
    checkOutput("busy_idle", busy_o, 0);
    checkAllV("v_after_sweep");
  endtask

  initial begin
    modelReset();
    for (int k = 0; k < N; k++) ii[k] = 0;

    $display("[TB] reset state");
    doReset();
    checkAllV("reset_v");
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_done", done_o, 0);
    checkOutput("reset_valid", spike_valid_o, 0);
    checkOutput("reset_overrun", overrun_o, 0);
    checkOutput("reset_spike_idx", spike_idx_o, 0);

    $display("[TB] zero current sweeps");
    applyStimulus(0, -1);
    rd_idx_i = 3'd0; #1; checkOutput("t2_v0_tick1", rd_v_o, -11);
    applyStimulus(0, -1);
    rd_idx_i = 3'd7; #1; checkOutput("t2_v7_tick2", rd_v_o, -7);

    $display("[TB] strong drive on neuron 3");
    doReset();
    ii[3] = 127;
    applyStimulus(0, -1);
    rd_idx_i = 3'd3; #1; checkOutput("t3_v3_tick1", rd_v_o, 20);
    applyStimulus(0, -1);
    rd_idx_i = 3'd3; #1; checkOutput("t3_v3_tick2", rd_v_o, 55);
    applyStimulus(0, -1);
    rd_idx_i = 3'd3; #1; checkOutput("t3_v3_tick3", rd_v_o, -20);
    checkOutput("t3_latency", lat, 26);
`ifdef QIF_REFRACTORY_EN
    for (int t = 0; t < 3; t++) begin
      applyStimulus(0, -1);
      rd_idx_i = 3'd3; #1; checkOutput("t6_refr_hold", rd_v_o, -20);
    end
    applyStimulus(0, -1);
    rd_idx_i = 3'd3; #1; checkOutput("t6_refr_release", rd_v_o, 20);
`endif

    $display("[TB] spike back-pressure");
    doReset();
    applyStimulus(0, -1);
    applyStimulus(0, -1);
    applyStimulus(5, -1);
    checkOutput("t4_latency", lat, 31);

    $display("[TB] overrun");
    applyStimulus(0, 10);
    checkOutput("t5_overrun_set", overrun_o, 1);
    repeat (3) @(negedge clk);
    checkOutput("t5_no_resweep", busy_o, 0);
    applyStimulus(0, -1);
    checkOutput("t5_overrun_sticky", overrun_o, 1);

    $display("[TB] reset mid-sweep");
    ii[3] = 0;
    applyStimulus(0, -1);
    driveI();
    @(negedge clk);
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    checkOutput("t6_busy", busy_o, 0);
    checkOutput("t6_valid", spike_valid_o, 0);
    checkOutput("t6_overrun_clr", overrun_o, 0);
    checkAllV("t6_v");
    repeat (3) @(negedge clk);
    checkOutput("t6_valid_later", spike_valid_o, 0);
    checkOutput("t6_busy_later", busy_o, 0);

    $display("[TB] randomized sweeps");
    for (int s = 0; s < 12; s++) begin
      for (int k = 0; k < N; k++) ii[k] = int'($urandom_range(0, 255)) - 128;
      if (s % 3 == 0) ii[$urandom_range(0, N - 1)] = 127;
      applyStimulus(-1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
